ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 110 +++++++++++
 tb/tb_ifetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch: FETCH->WAIT->HOLD, gnt to id_valid in 2 cycles at best.
// Backpressure: HOLD keeps id_* stable and issues nothing until id_ready; redirects drop stale responses.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [24:0] id_imm_field
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsbs;

  assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign imem_addr            = pc;
  assign id_imm_field         = id_inst[31:7];

  // imem_req is registered alongside state so it is high exactly in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_pc   <= 32'h0;
      id_valid <= 1'b0;
      id_inst  <= 32'h0;
      id_pc    <= 32'h0;
      imem_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= redirect_tgt;
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (redirect_valid) begin
            pc <= redirect_tgt;
            if (imem_gnt) begin
              state    <= DRAIN;
              imem_req <= 1'b0;
            end
          end else if (imem_gnt) begin
            req_pc   <= pc;
            pc       <= pc + 32'd4;
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc <= redirect_tgt;
            if (imem_rvalid) begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (imem_rvalid) begin
            id_inst  <= imem_rdata;
            id_pc    <= req_pc;
            id_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        DRAIN: begin
          // The response already in flight belongs to the old path; swallow it.
          if (redirect_valid) pc <= redirect_tgt;
          if (imem_rvalid) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc       <= redirect_tgt;
            id_valid <= 1'b0;
            state    <= FETCH;
            imem_req <= 1'b1;
          end else if (id_valid && id_ready) begin
            id_valid <= 1'b0;
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit; second instance covers a wrapping RESET_PC.
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n, imem_req, imem_gnt, imem_rvalid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_inst, id_pc;
  logic [24:0] id_imm_field;

  logic        rst_b_n, req_b, gnt_b, rvalid_b, redir_b, valid_b, ready_b;
  logic [31:0] addr_b, rdata_b, redir_pc_b, inst_b, pc_b;
  logic [24:0] imm_b;

  int checks = 0;
  int errors = 0;

  ifetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .id_imm_field(id_imm_field)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .imem_req(req_b), .imem_addr(addr_b),
    .imem_gnt(gnt_b), .imem_rvalid(rvalid_b), .imem_rdata(rdata_b),
    .redirect_valid(redir_b), .redirect_pc(redir_pc_b),
    .id_valid(valid_b), .id_ready(ready_b), .id_inst(inst_b), .id_pc(pc_b),
    .id_imm_field(imm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rst_b_n = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    gnt_b = 0; rvalid_b = 0; rdata_b = 0; redir_b = 0; redir_pc_b = 0; ready_b = 0;
    #1;
    rst_n = 1'b0; rst_b_n = 1'b0;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %0h want 0", id_valid); end
    checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0) begin errors++; $display("FAIL reset_id: got %h/%h want 0/0", id_inst, id_pc); end
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_fetch: got req %0h addr %h want 1 0", imem_req, imem_addr); end
  endtask

  task automatic test_basic();
    imem_gnt = 1; imem_rdata = 32'h0010_0093;
    step();
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL basic_wait: got req %0h vld %0h want 0 0", imem_req, id_valid); end
    imem_gnt = 0; imem_rvalid = 1; id_ready = 1;
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL basic_vld: got %0h want 1", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h want 0", id_pc); end
    checks++; if (id_inst !== 32'h0010_0093) begin errors++; $display("FAIL basic_inst: got %h want 00100093", id_inst); end
    checks++; if (id_imm_field !== 25'h000_2001) begin errors++; $display("FAIL basic_imm: got %h want 0002001", id_imm_field); end
    imem_rvalid = 0;
    step();
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL basic_next: got vld %0h req %0h addr %h want 0 1 4", id_valid, imem_req, imem_addr); end
  endtask

  task automatic test_hold_stall();
    id_ready = 0; imem_gnt = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_gnt = 0; imem_rvalid = 1;
    step();
    imem_rvalid = 0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL stall_enter: got %0h %h %h want 1 4 deadbeef", id_valid, id_pc, id_inst); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_inst !== 32'hDEAD_BEEF || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got vld %0h pc %h inst %h req %0h", i, id_valid, id_pc, id_inst, imem_req); end
    end
    id_ready = 1;
    step();
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL stall_release: got vld %0h req %0h addr %h want 0 1 8", id_valid, imem_req, imem_addr); end
    imem_gnt = 1; imem_rdata = 32'h6666_6666;
    step();
    imem_gnt = 0; imem_rvalid = 1;
    step();
    imem_rvalid = 0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8) begin errors++; $display("FAIL stall_refetch: got vld %0h pc %h want 1 8", id_valid, id_pc); end
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_next: got req %0h addr %h want 1 c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1; imem_rdata = 32'h1111_1111;
    step();
    imem_gnt = 0; redirect_valid = 1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 0;
    checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin errors++; $display("FAIL rw_drain1: got req %0h vld %0h want 0 0", imem_req, id_valid); end
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_drain2: got req %0h want 0", imem_req); end
    imem_rvalid = 1;
    step();
    imem_rvalid = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || id_valid !== 1'b0) begin
      errors++; $display("FAIL rw_refetch: got req %0h addr %h vld %0h want 1 100 0", imem_req, imem_addr, id_valid); end
    step();
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'h6666_6666) begin errors++; $display("FAIL rw_dropped: got vld %0h inst %h want 0 66666666", id_valid, id_inst); end
  endtask

  task automatic test_redirect_gnt();
    imem_gnt = 1; redirect_valid = 1; redirect_pc = 32'h0000_2000;
    step();
    imem_gnt = 0; redirect_valid = 0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rg_drain: got req %0h want 0", imem_req); end
    imem_rvalid = 1; imem_rdata = 32'h2222_2222;
    step();
    imem_rvalid = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || id_valid !== 1'b0) begin
      errors++; $display("FAIL rg_refetch: got req %0h addr %h vld %0h want 1 2000 0", imem_req, imem_addr, id_valid); end
  endtask

  task automatic test_redirect_fetch();
    redirect_valid = 1; redirect_pc = 32'h0000_3009;
    step();
    redirect_valid = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3008) begin errors++; $display("FAIL rf_addr: got req %0h addr %h want 1 3008", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_hold();
    imem_gnt = 1; imem_rdata = 32'h3333_3333;
    step();
    imem_gnt = 0; imem_rvalid = 1;
    step();
    imem_rvalid = 0;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3008) begin errors++; $display("FAIL rh_hold: got vld %0h pc %h want 1 3008", id_valid, id_pc); end
    redirect_valid = 1; redirect_pc = 32'h0000_4000; id_ready = 1;
    step();
    redirect_valid = 0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4000) begin
      errors++; $display("FAIL rh_redirect: got vld %0h req %0h addr %h want 0 1 4000", id_valid, imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait_rvalid();
    imem_gnt = 1;
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h4444_4444; redirect_valid = 1; redirect_pc = 32'h0000_5000;
    step();
    imem_rvalid = 0; redirect_valid = 0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000 || id_valid !== 1'b0 || id_inst !== 32'h3333_3333) begin
      errors++; $display("FAIL rwr: got req %0h addr %h vld %0h inst %h want 1 5000 0 33333333", imem_req, imem_addr, id_valid, id_inst); end
  endtask

  task automatic test_reset_mid();
    imem_gnt = 1;
    step();
    imem_gnt = 0;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL rm_async: got req %0h addr %h vld %0h want 0 0 0", imem_req, imem_addr, id_valid); end
    checks++; if (id_inst !== 32'h0 || id_pc !== 32'h0 || id_imm_field !== 25'h0) begin
      errors++; $display("FAIL rm_id_clear: got inst %h pc %h imm %h want 0", id_inst, id_pc, id_imm_field); end
    step(); step();
    rst_n = 1'b1; imem_rvalid = 1; imem_rdata = 32'h5555_5555;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rm_refetch: got req %0h addr %h want 1 0", imem_req, imem_addr); end
    step();
    imem_rvalid = 0;
    checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rm_stale: got vld %0h req %0h addr %h want 0 1 0", id_valid, imem_req, imem_addr); end
  endtask

  task automatic test_reset_pc_wrap();
    checks++; if (req_b !== 1'b0 || addr_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_reset: got req %0h addr %h want 0 fffffffc", req_b, addr_b); end
    rst_b_n = 1'b1;
    step();
    checks++; if (req_b !== 1'b1 || addr_b !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_fetch: got req %0h addr %h want 1 fffffffc", req_b, addr_b); end
    gnt_b = 1; rdata_b = 32'h7777_7777;
    step();
    gnt_b = 0; rvalid_b = 1;
    step();
    rvalid_b = 0;
    checks++; if (valid_b !== 1'b1 || pc_b !== 32'hFFFF_FFFC || inst_b !== 32'h7777_7777) begin
      errors++; $display("FAIL wrap_id: got vld %0h pc %h inst %h want 1 fffffffc 77777777", valid_b, pc_b, inst_b); end
    ready_b = 1;
    step();
    checks++; if (req_b !== 1'b1 || addr_b !== 32'h0) begin errors++; $display("FAIL wrap_next: got req %0h addr %h want 1 0", req_b, addr_b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_gnt();
    test_redirect_fetch();
    test_redirect_hold();
    test_redirect_wait_rvalid();
    test_reset_mid();
    test_reset_pc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
